// File: rtl/debug_view_pkg.sv
// Shared types and defaults for the debug display selector.
package debug_view_pkg;

   typedef enum logic [1:0] {
      MODE_MANUAL = 2'b00,
      MODE_SCAN   = 2'b01,
      MODE_HOLD   = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_MANUAL = 2'b00,
      ST_SCAN   = 2'b01,
      ST_HOLD   = 2'b10
   } state_e;

   localparam logic [31:0] ERR_PATTERN_DEF = 32'h0000_003F;

   // Reserved mode code falls back to manual selection.
   function automatic state_e mode_to_state(input mode_e m);
      case (m)
         MODE_SCAN: return ST_SCAN;
         MODE_HOLD: return ST_HOLD;
         default:   return ST_MANUAL;
      endcase
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for the auto-scan mode: counts while running, clears on request,
// flags the last cycle of a dwell period.
module dwell_timer #(
   parameter int DWELL = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic expire
);

   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] count;

   assign expire = (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (run) begin
         count <= expire ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/debug_view_sel.sv
// Debug display selector: manual select, timed auto-scan and frozen snapshot
// browsing of NUM_CH probe words onto a registered display bus.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_MANUAL | live ch_data[sel] shown, channel follows sel
// ST_SCAN   | live ch_data[cur_ch] shown, channel advances on dwell/step
// ST_HOLD   | snapshot[sel] shown, snapshot captured on entry edge
module debug_view_sel
   import debug_view_pkg::*;
#(
   parameter int          NUM_CH      = 8,
   parameter int          DATA_W      = 32,
   parameter int          DWELL       = 50_000_000,
   parameter logic [31:0] ERR_PATTERN = ERR_PATTERN_DEF,
   parameter int          SEL_W       = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic [SEL_W-1:0]         sel,
   input  logic [1:0]               mode,
   input  logic                     step,
   output logic [DATA_W-1:0]        show_data,
   output logic [SEL_W-1:0]         show_ch,
   output logic                     show_upd
);

   localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_PATTERN);

   logic [NUM_CH-1:0][DATA_W-1:0] live_bank;
   logic [NUM_CH-1:0][DATA_W-1:0] snap_bank;

   state_e            state_q, state_d;
   logic [SEL_W-1:0]  cur_ch_q, cur_ch_d, cur_ch_inc;
   logic [DATA_W-1:0] show_data_q, data_d;
   logic              show_upd_q, upd_d;
   logic              snap_load, hold_entry;
   logic              tmr_clr, tmr_run, tmr_expire;

   assign live_bank = ch_data;

   // Any index at or past the last channel (including out-of-range ones) wraps to 0.
   assign cur_ch_inc = (cur_ch_q >= SEL_W'(NUM_CH - 1)) ? '0 : cur_ch_q + SEL_W'(1);

   function automatic logic [DATA_W-1:0] pick(input logic [NUM_CH-1:0][DATA_W-1:0] bank,
                                              input logic [SEL_W-1:0] idx);
      logic [DATA_W-1:0] word;
      word = ERR_WORD;
      for (int k = 0; k < NUM_CH; k++) begin
         if (idx == SEL_W'(k)) word = bank[k];
      end
      return word;
   endfunction

   dwell_timer #(.DWELL(DWELL)) u_dwell (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (tmr_clr),
      .run    (tmr_run),
      .expire (tmr_expire)
   );

   always_comb begin
      state_d    = mode_to_state(mode_e'(mode));
      cur_ch_d   = cur_ch_q;
      data_d     = show_data_q;
      snap_load  = 1'b0;
      hold_entry = 1'b0;
      tmr_clr    = 1'b1;
      tmr_run    = 1'b0;

      case (state_d)
         ST_SCAN: begin
            // The entry edge only restarts the dwell period from the current channel.
            if (state_q == ST_SCAN) begin
               tmr_run = 1'b1;
               tmr_clr = step;
               if (step || tmr_expire) cur_ch_d = cur_ch_inc;
            end
            data_d = pick(live_bank, cur_ch_d);
         end
         ST_HOLD: begin
            cur_ch_d = sel;
            if (state_q != ST_HOLD) begin
               snap_load  = 1'b1;
               hold_entry = 1'b1;
               data_d     = pick(live_bank, sel);
            end else begin
               data_d = pick(snap_bank, sel);
            end
         end
         default: begin
            cur_ch_d = sel;
            data_d   = pick(live_bank, sel);
         end
      endcase

      upd_d = hold_entry || (cur_ch_d != cur_ch_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_MANUAL;
         cur_ch_q    <= '0;
         show_data_q <= '0;
         show_upd_q  <= 1'b0;
         snap_bank   <= '0;
      end else begin
         state_q     <= state_d;
         cur_ch_q    <= cur_ch_d;
         show_data_q <= data_d;
         show_upd_q  <= upd_d;
         if (snap_load) snap_bank <= live_bank;
      end
   end

   assign show_data = show_data_q;
   assign show_ch   = cur_ch_q;
   assign show_upd  = show_upd_q;

endmodule

// File: tb/tb_debug_view_sel.sv
// Scoreboard bench for debug_view_sel: an 8-channel and a 6-channel build share
// stimulus; a reference model queues expected display words for a monitor.
module tb_debug_view_sel;

   localparam int          DW  = 4;
   localparam logic [31:0] ERR = 32'h0000_003F;

   typedef struct packed {
      logic [31:0] data;
      logic [2:0]  ch;
      logic        upd;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [255:0] ch8;
   logic [191:0] ch6;
   logic [2:0]   sel;
   logic [1:0]   mode;
   logic         step;
   logic [31:0]  d8, d6;
   logic [2:0]   c8, c6;
   logic         u8, u6;

   logic [31:0] chd [8];
   exp_t        q8[$];
   exp_t        q6[$];
   int          n_vec = 0;
   int          n_bad = 0;

   int          m_prev [2];
   int          m_cur  [2];
   int          m_last [2];
   int          m_cnt  [2];
   logic [31:0] m_snap [2][8];

   debug_view_sel #(.NUM_CH(8), .DATA_W(32), .DWELL(DW)) dut8 (
      .clk(clk), .rst_n(rst_n), .ch_data(ch8), .sel(sel), .mode(mode), .step(step),
      .show_data(d8), .show_ch(c8), .show_upd(u8));

   debug_view_sel #(.NUM_CH(6), .DATA_W(32), .DWELL(DW)) dut6 (
      .clk(clk), .rst_n(rst_n), .ch_data(ch6), .sel(sel), .mode(mode), .step(step),
      .show_data(d6), .show_ch(c6), .show_upd(u6));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_prev[i] = 0;
         m_cur[i]  = 0;
         m_last[i] = 0;
         m_cnt[i]  = 0;
         for (int k = 0; k < 8; k++) m_snap[i][k] = '0;
      end
   endtask

   // m_cnt = cycles the current channel has already been on display in SCAN.
   task automatic model_edge(input int i, input int n, output exp_t e);
      int   nm;
      bit   entry;
      logic [31:0] v;
      nm    = (mode == 2'd3) ? 0 : int'(mode);
      entry = 1'b0;
      if (nm == 1) begin
         if (m_prev[i] != 1) begin
            m_cnt[i] = 0;
         end else begin
            m_cnt[i]++;
            if (step || m_cnt[i] == DW) begin
               m_cur[i] = (m_cur[i] >= n - 1) ? 0 : m_cur[i] + 1;
               m_cnt[i] = 0;
            end
         end
      end else if (nm == 2) begin
         if (m_prev[i] != 2) begin
            entry = 1'b1;
            for (int k = 0; k < n; k++) m_snap[i][k] = chd[k];
         end
         m_cur[i] = int'(sel);
      end else begin
         m_cur[i] = int'(sel);
      end
      if (nm == 2) v = (int'(sel) < n) ? m_snap[i][sel] : ERR;
      else         v = (m_cur[i] < n) ? chd[m_cur[i]] : ERR;
      e.data    = v;
      e.ch      = 3'(m_cur[i]);
      e.upd     = entry || (m_cur[i] != m_last[i]);
      m_last[i] = m_cur[i];
      m_prev[i] = nm;
   endtask

   task automatic drive(input logic [1:0] md, input logic [2:0] s, input logic st);
      exp_t e;
      @(negedge clk);
      rst_n = 1'b1;
      mode  = md;
      sel   = s;
      step  = st;
      for (int k = 0; k < 8; k++) ch8[k*32 +: 32] = chd[k];
      ch6 = ch8[191:0];
      model_edge(0, 8, e);
      q8.push_back(e);
      model_edge(1, 6, e);
      q6.push_back(e);
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called right after settle(); asserts reset between clock edges.
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      model_reset();
      q8.delete();
      q6.delete();
      #1;
      chk("rst_data8", d8, 32'h0);
      chk("rst_ch8", 32'(c8), 32'h0);
      chk("rst_upd8", 32'(u8), 32'h0);
      chk("rst_data6", d6, 32'h0);
      @(posedge clk);
      #1;
      chk("rst_hold_ch6", 32'(c6), 32'h0);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n) begin
         if (q8.size() > 0) begin
            e = q8.pop_front();
            n_vec++;
            if ({d8, c8, u8} !== e) begin
               n_bad++;
               $display("FAIL sb_dut8 @%0t: got data=%h ch=%0d upd=%0b expected data=%h ch=%0d upd=%0b",
                        $time, d8, c8, u8, e.data, e.ch, e.upd);
            end
         end
         if (q6.size() > 0) begin
            e = q6.pop_front();
            n_vec++;
            if ({d6, c6, u6} !== e) begin
               n_bad++;
               $display("FAIL sb_dut6 @%0t: got data=%h ch=%0d upd=%0b expected data=%h ch=%0d upd=%0b",
                        $time, d6, c6, u6, e.data, e.ch, e.upd);
            end
         end
      end
   end

   initial begin
      for (int k = 0; k < 8; k++) chd[k] = 32'h1000_0000 + k;
      for (int k = 0; k < 8; k++) ch8[k*32 +: 32] = chd[k];
      ch6  = ch8[191:0];
      mode = 2'd0;
      sel  = 3'd0;
      step = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data8", d8, 32'h0);
      chk("reset_ch8", 32'(c8), 32'h0);
      chk("reset_upd8", 32'(u8), 32'h0);

      drive(2'd0, 3'd3, 1'b0); settle();
      chk("man_data", d8, 32'h1000_0003);
      chk("man_ch", 32'(c8), 32'd3);
      chk("man_upd", 32'(u8), 32'd1);
      drive(2'd0, 3'd3, 1'b0); settle();
      chk("man_upd_once", 32'(u8), 32'd0);

      drive(2'd0, 3'd7, 1'b0);
      chd[7] = 32'hDEAD_BEEF;
      drive(2'd0, 3'd7, 1'b0); settle();
      chk("live_follow", d8, 32'hDEAD_BEEF);
      chk("live_no_upd", 32'(u8), 32'd0);
      chk("err6_data", d6, ERR);
      chk("err6_ch", 32'(c6), 32'd7);
      chd[7] = 32'h1000_0007;
      drive(2'd3, 3'd7, 1'b0);
      chd[7] = 32'hCAFE_F00D;
      drive(2'd3, 3'd7, 1'b0); settle();
      chk("rsvd_follow", d8, 32'hCAFE_F00D);
      chd[7] = 32'h1000_0007;

      drive(2'd0, 3'd6, 1'b0);
      repeat (16) drive(2'd1, 3'd0, 1'b0);
      settle();
      chk("scan_wrap_ch", 32'(c8), 32'd1);
      drive(2'd1, 3'd0, 1'b0);
      drive(2'd1, 3'd0, 1'b0);
      drive(2'd1, 3'd0, 1'b1); settle();
      chk("scan_step_cnt1", 32'(c8), 32'd3);
      repeat (3) drive(2'd1, 3'd0, 1'b0);
      drive(2'd1, 3'd0, 1'b1); settle();
      chk("scan_step_expiry", 32'(c8), 32'd4);

      drive(2'd0, 3'd7, 1'b0); settle();
      chk("n6_err_data", d6, ERR);
      repeat (4) drive(2'd1, 3'd0, 1'b0);
      settle();
      chk("n6_scan_err", d6, ERR);
      drive(2'd1, 3'd0, 1'b0); settle();
      chk("n6_scan_wrap", 32'(c6), 32'd0);
      chk("n6_scan_data", d6, 32'h1000_0000);

      chd[2] = 32'hAAAA_0002;
      drive(2'd2, 3'd2, 1'b0); settle();
      chk("hold_data", d8, 32'hAAAA_0002);
      chk("hold_upd", 32'(u8), 32'd1);
      for (int k = 0; k < 8; k++) chd[k] = 32'h5555_0000 + k;
      drive(2'd2, 3'd2, 1'b0); settle();
      chk("hold_frozen", d8, 32'hAAAA_0002);
      drive(2'd2, 3'd5, 1'b1); settle();
      chk("hold_sel5", d8, 32'h1000_0005);
      chk("hold_sel5_n6", d6, 32'h1000_0005);
      drive(2'd2, 3'd5, 1'b1); settle();
      chk("hold_step_ign", 32'(c8), 32'd5);
      for (int k = 0; k < 8; k++) chd[k] = 32'h1000_0000 + k;

      drive(2'd0, 3'd4, 1'b0);
      drive(2'd1, 3'd0, 1'b0);
      drive(2'd1, 3'd0, 1'b0); settle();
      chk("pre_rst_ch", 32'(c8), 32'd4);
      async_reset();
      drive(2'd0, 3'd2, 1'b0); settle();
      chk("post_rst_ch", 32'(c8), 32'd2);
      chk("post_rst_data", d8, 32'h1000_0002);

      for (int it = 0; it < 2000; it++) begin
         logic [1:0] md;
         md = mode;
         if ($urandom_range(0, 7) == 0) md = 2'($urandom_range(0, 3));
         for (int k = 0; k < 8; k++)
            if ($urandom_range(0, 3) == 0) chd[k] = $urandom;
         drive(md, 3'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0));
         if ($urandom_range(0, 299) == 0) begin
            settle();
            async_reset();
         end
      end
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
